// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Purpose  : Memory-mapped peripheral responder on the CPU data port. It
//            answers reads and writes in a 32-byte window and ignores all
//            other addresses. It contains a console TX FIFO drained by a
//            valid/ready byte stream and a free-running 64-bit cycle timer.
//            The timer has an optional compare interrupt.
// Options  : `define MMIO_TIMER_CMP_EN implements MTIMECMP_LO/HI and the
//            compare interrupt. Without it, offsets 4/5 read 0, writes to
//            them are ignored, and o_timer_irq is tied low.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            data_addr_r     - read address, sampled every cycle
//            data_r, o_hit_r - registered read data / window-hit flag
//            data_w_en, data_addr_w, data_w, data_len_w - write port
//            o_tx_data, o_tx_valid, i_tx_ready - console byte stream
//            o_timer_irq     - registered timer compare interrupt
// Register map (offset = addr[4:2]):
//            0 TXDATA, 1 STATUS, 2 MTIME_LO, 3 MTIME_HI,
//            4 MTIMECMP_LO, 5 MTIMECMP_HI, 6/7 reserved
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr_r,
    output logic [31:0] data_r,
    output logic        o_hit_r,
    input  logic        data_w_en,
    input  logic [31:0] data_addr_w,
    input  logic [31:0] data_w,
    input  logic [1:0]  data_len_w,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_timer_irq
);

    localparam int                c_PTR_W       = $clog2(TX_DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL_CNT    = (c_PTR_W + 1)'(TX_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [2:0]        c_OFF_TXDATA  = 3'd0;
    localparam logic [2:0]        c_OFF_STATUS  = 3'd1;
    localparam logic [2:0]        c_OFF_MTLO    = 3'd2;
    localparam logic [2:0]        c_OFF_MTHI    = 3'd3;
    localparam logic [2:0]        c_OFF_CMPLO   = 3'd4;
    localparam logic [2:0]        c_OFF_CMPHI   = 3'd5;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_rd_win;
    logic [2:0] w_rd_off;
    logic       w_wr_ok;
    logic [2:0] w_wr_off;
    logic       w_unused_rd_lsb;

    assign w_rd_win = (data_addr_r[31:5] == BASE_ADDR[31:5]);
    assign w_rd_off = data_addr_r[4:2];
    assign w_wr_off = data_addr_w[4:2];
    // Length code 11 is not a legal size and is treated as no write at all.
    assign w_wr_ok  = data_w_en && (data_addr_w[31:5] == BASE_ADDR[31:5])
                      && (data_len_w != 2'b11);
    // Read accesses are word-granular; the byte offset bits carry no meaning.
    assign w_unused_rd_lsb = &{1'b0, data_addr_r[1:0]};

    // ------------------------------------------------------------------
    // Lane merge: byte enables plus the write data replicated onto every
    // lane, so each byte lane just selects old or new.
    // ------------------------------------------------------------------
    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_data;

    always_comb begin
        w_lane_be   = 4'b0000;
        w_lane_data = data_w;
        case (data_len_w)
            2'b00: begin
                w_lane_be   = 4'b0001 << data_addr_w[1:0];
                w_lane_data = {4{data_w[7:0]}};
            end
            2'b01: begin
                w_lane_be   = data_addr_w[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{data_w[15:0]}};
            end
            2'b10:   w_lane_be = 4'b1111;
            default: w_lane_be = 4'b0000;
        endcase
    end

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [3:0]  be,
                                            input logic [31:0] wd);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Console TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_fifo [TX_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_ovf_set;
    logic               w_ovf_clr;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_CNT);
    assign o_tx_valid = !w_empty;
    assign o_tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign w_pop      = o_tx_valid && i_tx_ready;
    assign w_push_req = w_wr_ok && (w_wr_off == c_OFF_TXDATA);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is accepted whenever the sink is draining.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_wr_ok && (w_wr_off == c_OFF_STATUS) && data_w[2];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= data_w[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Clear has priority over a simultaneous overflow.
            if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // 64-bit timer. A write replaces the value for that cycle instead of
    // incrementing it.
    // ------------------------------------------------------------------
    logic [63:0] r_mtime;
    logic [63:0] w_mtime_next;
    logic [31:0] r_mtime_shadow;

    always_comb begin
        w_mtime_next = r_mtime + 64'd1;
        if (w_wr_ok && (w_wr_off == c_OFF_MTLO)) begin
            w_mtime_next = {r_mtime[63:32], f_merge(r_mtime[31:0], w_lane_be, w_lane_data)};
        end else if (w_wr_ok && (w_wr_off == c_OFF_MTHI)) begin
            w_mtime_next = {f_merge(r_mtime[63:32], w_lane_be, w_lane_data), r_mtime[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime        <= 64'd0;
            r_mtime_shadow <= 32'd0;
        end else begin
            r_mtime <= w_mtime_next;
            // Reading LO latches HI so a LO-then-HI sequence is coherent.
            if (w_rd_win && (w_rd_off == c_OFF_MTLO)) begin
                r_mtime_shadow <= r_mtime[63:32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional compare interrupt
    // ------------------------------------------------------------------
    logic        w_irq;
    logic [31:0] w_cmp_lo;
    logic [31:0] w_cmp_hi;

`ifdef MMIO_TIMER_CMP_EN
    logic [63:0] r_mtimecmp;
    logic        r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
            if (w_wr_ok && (w_wr_off == c_OFF_CMPLO)) begin
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], w_lane_be, w_lane_data);
            end
            if (w_wr_ok && (w_wr_off == c_OFF_CMPHI)) begin
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], w_lane_be, w_lane_data);
            end
        end
    end

    assign w_irq    = r_irq;
    assign w_cmp_lo = r_mtimecmp[31:0];
    assign w_cmp_hi = r_mtimecmp[63:32];
`else
    assign w_irq    = 1'b0;
    assign w_cmp_lo = 32'd0;
    assign w_cmp_hi = 32'd0;
`endif

    assign o_timer_irq = w_irq;

    // ------------------------------------------------------------------
    // Read path: one cycle latency, all values taken pre-write.
    // ------------------------------------------------------------------
    logic [31:0] w_rd_data;
    logic [31:0] r_data_r;
    logic        r_hit_r;

    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_off)
            c_OFF_STATUS: w_rd_data = {28'd0, w_irq, r_overflow, w_full, w_empty};
            c_OFF_MTLO:   w_rd_data = r_mtime[31:0];
            c_OFF_MTHI:   w_rd_data = r_mtime_shadow;
            c_OFF_CMPLO:  w_rd_data = w_cmp_lo;
            c_OFF_CMPHI:  w_rd_data = w_cmp_hi;
            default:      w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_r <= 32'd0;
            r_hit_r  <= 1'b0;
        end else begin
            r_hit_r  <= w_rd_win;
            r_data_r <= w_rd_win ? w_rd_data : 32'd0;
        end
    end

    assign data_r  = r_data_r;
    assign o_hit_r = r_hit_r;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Purpose  : Self-checking bench for mmio_responder. A behavioural model
//            (64-bit integers, a byte queue for the FIFO) predicts every
//            read response; a scoreboard queue carries the predictions to a
//            monitor that compares them with the DUT outputs. The monitor
//            also checks the TX stream and the interrupt every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_addr_r;
    logic [31:0] data_r;
    logic        o_hit_r;
    logic        data_w_en;
    logic [31:0] data_addr_w;
    logic [31:0] data_w;
    logic [1:0]  data_len_w;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_timer_irq;

    mmio_responder #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_addr_r (data_addr_r),
        .data_r      (data_r),
        .o_hit_r     (o_hit_r),
        .data_w_en   (data_w_en),
        .data_addr_w (data_addr_w),
        .data_w      (data_w),
        .data_len_w  (data_len_w),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_timer_irq (o_timer_irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic        m_ovf;
    logic        m_irq;
    logic [7:0]  m_fifo [$];

    typedef struct {
        int          due;
        logic        hit;
        logic [31:0] data;
    } exp_t;

    exp_t sb [$];
    int   edges    = 0;
    bit   checking = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;

    function automatic bit in_win(input logic [31:0] a);
        return (a - BASE) < 32'd32;
    endfunction

    function automatic int reg_index(input logic [31:0] a);
        return int'((a - BASE) / 32'd4);
    endfunction

    // Replace the addressed lanes of a 32-bit word.
    function automatic logic [31:0] apply_write(input logic [31:0] old_val,
                                                input logic [31:0] wd,
                                                input logic [1:0]  len,
                                                input logic [1:0]  a);
        logic [31:0] r;
        r = old_val;
        if (len == 2'd0)      r[int'(a) * 8 +: 8] = wd[7:0];
        else if (len == 2'd1) r[(a >= 2'd2 ? 16 : 0) +: 16] = wd[15:0];
        else if (len == 2'd2) r = wd;
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        int  n;
        bit  cmp_en;
        n = m_fifo.size();
`ifdef MMIO_TIMER_CMP_EN
        cmp_en = 1'b1;
`else
        cmp_en = 1'b0;
`endif
        case (idx)
            1: return {28'd0, m_irq, m_ovf, n == DEPTH, n == 0};
            2: return m_mtime[31:0];
            3: return m_shadow;
            4: return cmp_en ? m_cmp[31:0]  : 32'd0;
            5: return cmp_en ? m_cmp[63:32] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = {64{1'b1}};
        m_shadow = 32'd0;
        m_ovf    = 1'b0;
        m_irq    = 1'b0;
        m_fifo.delete();
    endtask

    // One clock cycle: predict the read, let the edge happen, then advance
    // the model with the inputs that were sampled at that edge.
    task automatic step();
        exp_t        e;
        bit          wr;
        int          widx;
        bit          pop;
        bit          was_full;
        logic        irq_next;
        e.due  = edges + 1;
        e.hit  = 1'b0;
        e.data = 32'd0;
        if (!rst && in_win(data_addr_r)) begin
            e.hit  = 1'b1;
            e.data = model_read(reg_index(data_addr_r));
        end
        sb.push_back(e);
        @(posedge clk);
        edges++;
        if (rst) begin
            model_reset();
        end else begin
`ifdef MMIO_TIMER_CMP_EN
            irq_next = (m_mtime >= m_cmp);
`else
            irq_next = 1'b0;
`endif
            if (in_win(data_addr_r) && reg_index(data_addr_r) == 2) begin
                m_shadow = m_mtime[63:32];
            end
            wr   = data_w_en && in_win(data_addr_w) && (data_len_w != 2'b11);
            widx = wr ? reg_index(data_addr_w) : -1;
            was_full = (m_fifo.size() == DEPTH);
            pop  = (m_fifo.size() != 0) && i_tx_ready;
            if (pop) void'(m_fifo.pop_front());
            if (widx == 0) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else                  m_fifo.push_back(data_w[7:0]);
            end
            if (widx == 1 && data_w[2]) m_ovf = 1'b0;
            if (widx == 2)
                m_mtime[31:0] = apply_write(m_mtime[31:0], data_w, data_len_w, data_addr_w[1:0]);
            else if (widx == 3)
                m_mtime[63:32] = apply_write(m_mtime[63:32], data_w, data_len_w, data_addr_w[1:0]);
            else
                m_mtime = m_mtime + 64'd1;
`ifdef MMIO_TIMER_CMP_EN
            if (widx == 4)
                m_cmp[31:0] = apply_write(m_cmp[31:0], data_w, data_len_w, data_addr_w[1:0]);
            if (widx == 5)
                m_cmp[63:32] = apply_write(m_cmp[63:32], data_w, data_len_w, data_addr_w[1:0]);
`endif
            m_irq = irq_next;
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: read responses from the scoreboard, stream and irq vs model
    // ------------------------------------------------------------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (checking) begin
            while (sb.size() != 0 && sb[0].due <= edges) begin
                mon_e = sb.pop_front();
                n_vec++;
                if (o_hit_r !== mon_e.hit || data_r !== mon_e.data) begin
                    n_err++;
                    $display("FAIL read_resp cycle=%0d got hit=%0b data=%08h expected hit=%0b data=%08h",
                             edges, o_hit_r, data_r, mon_e.hit, mon_e.data);
                end
            end
            n_vec++;
            if (o_tx_valid !== (m_fifo.size() != 0) ||
                o_tx_data !== ((m_fifo.size() != 0) ? m_fifo[0] : 8'h00)) begin
                n_err++;
                $display("FAIL tx_stream cycle=%0d got valid=%0b data=%02h expected valid=%0b data=%02h",
                         edges, o_tx_valid, o_tx_data, m_fifo.size() != 0,
                         (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
            end
            n_vec++;
            if (o_timer_irq !== m_irq) begin
                n_err++;
                $display("FAIL timer_irq cycle=%0d got %0b expected %0b", edges, o_timer_irq, m_irq);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        data_w_en   = 1'b0;
        data_addr_r = 32'h0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [31:0] a);
        data_w_en   = 1'b0;
        data_addr_r = a;
        step();
        data_addr_r = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
        data_w_en   = 1'b1;
        data_addr_w = a;
        data_w      = d;
        data_len_w  = len;
        step();
        data_w_en   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        data_addr_r = 32'h0;
        data_w_en   = 1'b0;
        data_addr_w = 32'h0;
        data_w      = 32'h0;
        data_len_w  = 2'b10;
        i_tx_ready  = 1'b0;
        model_reset();
        #1;
        step();
        checking = 1'b1;
        step();
        rst = 1'b0;

        // Timer counts from reset
        idle(5);
        rd(BASE + 32'h08);

        // Three bytes held, then drained back to back
        wr(BASE, 32'h41, 2'b10);
        wr(BASE, 32'h42, 2'b10);
        wr(BASE, 32'h43, 2'b10);
        idle(3);
        i_tx_ready = 1'b1;
        idle(5);
        i_tx_ready = 1'b0;

        // Fill, overflow, clear, push+pop while full
        for (int i = 0; i < DEPTH + 1; i++) wr(BASE, 32'h50 + i, 2'b00);
        rd(BASE + 32'h04);
        wr(BASE + 32'h04, 32'h4, 2'b10);
        rd(BASE + 32'h04);
        i_tx_ready = 1'b1;
        wr(BASE, 32'h99, 2'b00);
        i_tx_ready = 1'b0;
        rd(BASE + 32'h04);
        i_tx_ready = 1'b1;
        idle(DEPTH + 2);
        rd(BASE + 32'h04);

        // Coherent 64-bit read across the LO carry, then a byte lane write
        wr(BASE + 32'h0C, 32'h1, 2'b10);
        wr(BASE + 32'h08, 32'hFFFF_FFF0, 2'b10);
        idle(32);
        rd(BASE + 32'h08);
        rd(BASE + 32'h0C);
        wr(BASE + 32'h09, 32'hAB, 2'b00);
        rd(BASE + 32'h08);
        wr(BASE + 32'h0E, 32'h1234, 2'b01);
        rd(BASE + 32'h08);
        rd(BASE + 32'h0C);

        // Compare interrupt
        wr(BASE + 32'h14, 32'h0, 2'b10);
        wr(BASE + 32'h10, 32'd100, 2'b10);
        wr(BASE + 32'h0C, 32'h0, 2'b10);
        wr(BASE + 32'h08, 32'd90, 2'b10);
        rd(BASE + 32'h10);
        idle(14);
        rd(BASE + 32'h04);
        rd(BASE + 32'h14);

        // Out-of-window read, illegal length, reserved offsets
        rd(32'h0000_0040);
        wr(BASE + 32'h08, 32'h1234, 2'b11);
        wr(BASE, 32'h77, 2'b11);
        wr(BASE + 32'h18, 32'hFFFF_FFFF, 2'b10);
        rd(BASE + 32'h08);
        rd(BASE + 32'h18);
        rd(BASE + 32'h1C);

        // Reset discards queued bytes
        i_tx_ready = 1'b0;
        wr(BASE, 32'h11, 2'b00);
        wr(BASE, 32'h22, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_tx_ready = 1'b1;
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 499) == 0);
            i_tx_ready  = ($urandom_range(0, 2) != 0);
            data_addr_r = ($urandom_range(0, 7) == 0) ? $urandom
                          : BASE + $urandom_range(0, 31);
            data_w_en   = ($urandom_range(0, 2) == 0);
            data_addr_w = ($urandom_range(0, 7) == 0) ? $urandom
                          : BASE + $urandom_range(0, 31);
            data_w      = $urandom;
            data_len_w  = 2'($urandom_range(0, 3));
            step();
        end
        rst       = 1'b0;
        data_w_en = 1'b0;
        idle(2);

        n_vec++;
        if (sb.size() > 1) begin
            n_err++;
            $display("FAIL sb_drain got %0d pending expected at most 1", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
